// File: rtl/wptr_full_sync.sv
// Write-side pointer, full flag and fill level for the async FIFO (wclk domain).
// Optional sticky overflow flag enabled by defining WPTR_OVERFLOW_DETECT_EN.
module wptr_full_sync #(
    parameter int ADDRSIZE           = 6,
    parameter int ALMOST_FULL_THRESH = 2
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   rptr_async,
    input  logic                wovf_clr,
    output logic                wen,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wbin,
    output logic [ADDRSIZE:0]   wptr,
    output logic [ADDRSIZE:0]   wq2_rptr,
    output logic                wfull,
    output logic                almost_full,
    output logic [ADDRSIZE:0]   wcount,
    output logic                woverflow
);

    localparam logic [ADDRSIZE:0] DEPTH = {1'b1, {ADDRSIZE{1'b0}}};
    localparam int AF_INT = (1 << ADDRSIZE) - ALMOST_FULL_THRESH;
    localparam logic [ADDRSIZE:0] AF_LEVEL = AF_INT[ADDRSIZE:0];

    function automatic logic [ADDRSIZE:0] bin_to_gray(input logic [ADDRSIZE:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADDRSIZE:0] gray_to_bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDRSIZE:0] wq1_rptr;
    logic [ADDRSIZE:0] wbinnext;
    logic [ADDRSIZE:0] wgraynext;
    logic [ADDRSIZE:0] rbin_s;
    logic [ADDRSIZE:0] fill_next;
    logic [ADDRSIZE:0] full_cmp;
    logic              wfull_next;
    logic              af_next;

    assign wen   = winc & ~wfull;
    assign waddr = wbin[ADDRSIZE-1:0];

    // Next pointer, full compare and fill level derived from the synced read pointer.
    always_comb begin
        wbinnext   = wbin + {{ADDRSIZE{1'b0}}, wen};
        wgraynext  = bin_to_gray(wbinnext);
        full_cmp   = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
        wfull_next = (wgraynext == full_cmp);
        rbin_s     = gray_to_bin(wq2_rptr);
        fill_next  = wbinnext - rbin_s;
        af_next    = (fill_next >= AF_LEVEL) && (fill_next != DEPTH);
    end

    // Two-flop synchronizer bringing the Gray read pointer into wclk.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wq1_rptr <= '0;
            wq2_rptr <= '0;
        end else begin
            wq1_rptr <= rptr_async;
            wq2_rptr <= wq1_rptr;
        end
    end

    // Write pointers and registered status flags.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin        <= '0;
            wptr        <= '0;
            wfull       <= 1'b0;
            almost_full <= 1'b0;
            wcount      <= '0;
        end else begin
            wbin        <= wbinnext;
            wptr        <= wgraynext;
            wfull       <= wfull_next;
            almost_full <= af_next;
            wcount      <= fill_next;
        end
    end

`ifdef WPTR_OVERFLOW_DETECT_EN
    // Sticky overflow; a new write-while-full wins over a clear in the same cycle.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            woverflow <= 1'b0;
        end else if (winc & wfull) begin
            woverflow <= 1'b1;
        end else if (wovf_clr) begin
            woverflow <= 1'b0;
        end
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = wovf_clr;
    assign woverflow      = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full_sync.sv
// Scoreboard bench for wptr_full_sync at default parameters (depth 64).
// Stimulus queues expected outputs; a negedge monitor pops and compares them.
module tb_wptr_full_sync;

    typedef struct {
        int         step;
        logic [8:0] m;
        logic [6:0] b;
        logic [6:0] p;
        logic [6:0] q2;
        logic [6:0] c;
        logic       f;
        logic       a;
        logic       o;
        logic       en;
        logic [5:0] ad;
    } exp_t;

    localparam logic [8:0] ALL = 9'h1FF;

`ifdef WPTR_OVERFLOW_DETECT_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    logic       wclk = 1'b0;
    logic       wrst;
    logic       winc;
    logic [6:0] rptr_async;
    logic       wovf_clr;
    logic       wen;
    logic [5:0] waddr;
    logic [6:0] wbin;
    logic [6:0] wptr;
    logic [6:0] wq2_rptr;
    logic       wfull;
    logic       almost_full;
    logic [6:0] wcount;
    logic       woverflow;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    wptr_full_sync #(.ADDRSIZE(6), .ALMOST_FULL_THRESH(2)) dut (
        .wclk        (wclk),
        .wrst        (wrst),
        .winc        (winc),
        .rptr_async  (rptr_async),
        .wovf_clr    (wovf_clr),
        .wen         (wen),
        .waddr       (waddr),
        .wbin        (wbin),
        .wptr        (wptr),
        .wq2_rptr    (wq2_rptr),
        .wfull       (wfull),
        .almost_full (almost_full),
        .wcount      (wcount),
        .woverflow   (woverflow)
    );

    always #5 wclk = ~wclk;

    function automatic exp_t mk(int step, logic [8:0] m, logic [6:0] b,
                                logic [6:0] p, logic [6:0] q2, logic [6:0] c,
                                logic f, logic a, logic o, logic en,
                                logic [5:0] ad);
        exp_t e;
        e.step = step; e.m = m; e.b = b; e.p = p; e.q2 = q2; e.c = c;
        e.f = f; e.a = a; e.o = o; e.en = en; e.ad = ad;
        return e;
    endfunction

    function automatic logic [6:0] gray(int i);
        logic [6:0] v;
        v = 7'(i);
        return v ^ (v >> 1);
    endfunction

    function void chk(string n, int s, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0h required=%0h", n, s, act, req);
        end
    endfunction

    // Monitor: compare whatever the stimulus queued for the edge just past.
    always @(negedge wclk) begin
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.m[0]) chk("wbin", e.step, 32'(wbin), 32'(e.b));
            if (e.m[1]) chk("wptr", e.step, 32'(wptr), 32'(e.p));
            if (e.m[2]) chk("wq2_rptr", e.step, 32'(wq2_rptr), 32'(e.q2));
            if (e.m[3]) chk("wcount", e.step, 32'(wcount), 32'(e.c));
            if (e.m[4]) chk("wfull", e.step, 32'(wfull), 32'(e.f));
            if (e.m[5]) chk("almost_full", e.step, 32'(almost_full), 32'(e.a));
            if (e.m[6]) chk("woverflow", e.step, 32'(woverflow), 32'(e.o));
            if (e.m[7]) chk("wen", e.step, 32'(wen), 32'(e.en));
            if (e.m[8]) chk("waddr", e.step, 32'(waddr), 32'(e.ad));
        end
    end

    // Clock edge, queue the expectation, then return after the monitor's negedge.
    task automatic step(input exp_t e);
        @(posedge wclk);
        #1;
        q.push_back(e);
        @(negedge wclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        wrst = 1'b1; winc = 1'b1; wovf_clr = 1'b0; rptr_async = '0;

        for (int k = 1; k <= 2; k++)
            step(mk(k, ALL, 0, 0, 0, 0, 0, 0, 0, 1, 0));

        wrst = 1'b0; winc = 1'b0;
        step(mk(3, ALL, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        winc = 1'b1;
        for (int i = 1; i <= 64; i++)
            step(mk(100 + i, ALL, 7'(i),
                    (i == 64) ? 7'b1100000 : gray(i), 0, 7'(i),
                    i == 64, (i == 62) || (i == 63), 0, i != 64, 6'(i)));

        for (int k = 1; k <= 3; k++)
            step(mk(200 + k, ALL, 64, 7'b1100000, 0, 64, 1, 0, OVF, 0, 0));

        wovf_clr = 1'b1;
        step(mk(204, ALL, 64, 7'b1100000, 0, 64, 1, 0, OVF, 0, 0));
        winc = 1'b0;
        step(mk(205, ALL, 64, 7'b1100000, 0, 64, 1, 0, 0, 0, 0));
        wovf_clr = 1'b0;

        rptr_async = 7'b0000001;
        step(mk(301, ALL, 64, 7'b1100000, 0, 64, 1, 0, 0, 0, 0));
        step(mk(302, ALL, 64, 7'b1100000, 1, 64, 1, 0, 0, 0, 0));
        step(mk(303, ALL, 64, 7'b1100000, 1, 63, 0, 1, 0, 0, 0));

        wrst = 1'b1; rptr_async = '0;
        step(mk(400, ALL, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        wrst = 1'b0; winc = 1'b1;
        for (int i = 1; i <= 130; i++) begin
            step(mk(500 + i, ALL, 7'(i % 128), gray(i % 128),
                    (i >= 2) ? gray((i - 2) % 128) : 7'd0,
                    (i < 3) ? 7'(i) : 7'd3, 0, 0, 0, 1, 6'(i % 64)));
            rptr_async = gray(i % 128);
        end

        wrst = 1'b1; winc = 1'b0; rptr_async = '0;
        step(mk(600, ALL, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        wrst = 1'b0; winc = 1'b1;
        for (int i = 1; i <= 40; i++)
            step(mk(600 + i, 9'h009, 7'(i), 0, 0, 7'(i), 0, 0, 0, 0, 0));

        wrst = 1'b1; rptr_async = 7'b0000101;
        step(mk(700, ALL, 0, 0, 0, 0, 0, 0, 0, 1, 0));

        wrst = 1'b0; winc = 1'b0; rptr_async = '0;
        repeat (3) @(negedge wclk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
